rf_wb_arbiter: RTL
==================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter DATA_W, 32, write-data width.
REQ-002 Parameter ADDR_W, 5, register-address width (32 registers).
REQ-003 clock  in  1  single clock; all state changes on the rising edge.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 req0_valid  in  1  ALU writeback request valid.
REQ-006 req0_addr  in  ADDR_W  ALU destination register.
REQ-007 req0_data  in  DATA_W  ALU result.
REQ-008 req0_ready  out  1  ALU request accepted this cycle.
REQ-009 req1_valid, req1_addr, req1_data, req1_ready: same as REQ-005 to REQ-008, for the load/memory writeback port.
REQ-010 stall  in  1  when high, blocks acceptance of new requests.
REQ-011 RegWrite  out  1  register-file write enable.
REQ-012 WriteReg  out  ADDR_W  register-file write address.
REQ-013 WriteData  out  DATA_W  register-file write data.
REQ-014 conflict_cnt  out  16  count of cycles where both requesters were valid (present only with the macro in REQ-031).

Function
REQ-015 The block SHALL share the single register-file write port between req0 and req1 using valid/ready handshakes.
REQ-016 Ready SHALL be combinational: reqN_ready = grantN & ~stall; at most one ready SHALL be high per cycle.
REQ-017 A transfer occurs when reqN_valid & reqN_ready are high at a rising edge; requesters SHALL hold addr/data stable until that transfer.
REQ-018 With one valid requester, that requester SHALL be granted; with none, no grant is made.
REQ-019 With both valid, the requester not granted most recently SHALL win; the last_grant pointer SHALL update only on a transfer.
REQ-020 Output stage states: IDLE (RegWrite=0) and WRITE (RegWrite=1); a transfer at edge k SHALL move to WRITE for exactly cycle k+1, otherwise the stage returns to IDLE.
REQ-021 Latency: the accepted address and data SHALL appear on WriteReg/WriteData in the cycle after the transfer (1 cycle); a transfer every cycle SHALL be sustainable, giving full throughput.
REQ-022 A transfer to address 0 SHALL complete the handshake, update WriteReg/WriteData and the pointer, and hold RegWrite low.
REQ-023 When no transfer occurs, WriteReg/WriteData SHALL hold their previous values.
REQ-024 stall high SHALL force both readies low, leave last_grant unchanged, and produce RegWrite=0 in the following cycle.
REQ-025 A requester that drops valid before being granted SHALL lose no pointer state; the request simply does not occur.

Reset
REQ-026 On reset_n low, immediately and independently of clock: RegWrite=0, WriteReg=0, WriteData=0, state IDLE, conflict_cnt=0.
REQ-027 After reset, last_grant SHALL indicate req1, so req0 wins the first tie.
REQ-028 A request in flight at reset assertion SHALL be discarded; no write SHALL be issued after reset_n deasserts unless a new transfer occurs.
REQ-029 Readies SHALL be low while reset_n is low.
REQ-030 Release of reset_n is synchronized externally; the first arbitration occurs on the first edge with reset_n high.

Configuration
REQ-031 With RF_WB_STATS_EN defined, conflict_cnt SHALL increment on every edge where req0_valid & req1_valid & ~stall, saturating at 16'hFFFF.
REQ-032 Without RF_WB_STATS_EN, the conflict_cnt port and its counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-033 The shared package rf_pkg SHALL hold DATA_W, ADDR_W and typedef wb_req_t {addr, data}.
REQ-034 The two-way round-robin grant logic, including the last_grant flop, SHALL be a sub-module rr_arb2 (inputs: req[1:0], advance; output: one-hot gnt[1:0]).
REQ-035 rf_wb_arbiter SHALL instantiate rr_arb2 plus the output-stage flops and the optional statistics counter.

Verification
REQ-036 Reset, then req0 only, addr=3, data=32'hA5A5_0001 -> req0_ready=1 immediately; next cycle RegWrite=1, WriteReg=3, WriteData=A5A5_0001.
REQ-037 Both valid for 4 cycles (req0 addr=1, req1 addr=2) -> grant order req0, req1, req0, req1; RegWrite high for 4 consecutive cycles; conflict_cnt=4 with the macro defined.
REQ-038 req1 valid with addr=0, data=FFFF_FFFF -> req1_ready=1; next cycle RegWrite=0, WriteReg=0, WriteData=FFFF_FFFF.
REQ-039 Both valid with stall=1 for 3 cycles, then stall=0 -> no readies and RegWrite=0 during the stall; the pointer is unchanged; the first grant after the stall follows REQ-019.
REQ-040 Transfer at edge k, reset_n pulsed low mid-cycle k+1 -> RegWrite drops to 0 asynchronously and stays 0 after release while valids are low.
REQ-041 With the macro defined, force conflict_cnt to FFFE and apply 3 conflict cycles -> conflict_cnt=FFFF, no wrap.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg: shared widths, writeback request type and output-stage states
package rf_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;
    typedef enum logic {IDLE, WRITE} wb_state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; lastGrant moves only when a grant is consumed
module rr_arb2 (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    logic lastGrant;
    always_comb gnt = &req ? (lastGrant ? 2'b01 : 2'b10) : req;
    // Reset points at req1 so req0 wins the first tie
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) lastGrant <= 1'b1;
        else if (advance) lastGrant <= gnt[1];
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares one register-file write port between ALU and load writeback.
// Define RF_WB_STATS_EN to add the saturating conflict_cnt port.
module rf_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              stall,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData
`ifdef RF_WB_STATS_EN
    ,
    output logic [15:0]       conflict_cnt
`endif
);
    import rf_pkg::*;
    logic [1:0] gnt;
    logic [1:0] xfer;
    wb_req_t sel;
    wb_state_t state, stateNext;
    assign req0_ready = gnt[0] & ~stall & reset_n;
    assign req1_ready = gnt[1] & ~stall & reset_n;
    assign xfer = {req1_valid & req1_ready, req0_valid & req0_ready};
    rr_arb2 u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req     ({req1_valid, req0_valid}),
        .advance (|xfer),
        .gnt     (gnt)
    );
    always_comb begin
        sel.addr = xfer[1] ? req1_addr : req0_addr;
        sel.data = xfer[1] ? req1_data : req0_data;
        stateNext = |xfer ? WRITE : IDLE;
    end
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= stateNext;
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            WriteReg <= '0;
            WriteData <= '0;
        end else if (|xfer) begin
            WriteReg <= sel.addr;
            WriteData <= sel.data;
        end
    // Register 0 is hardwired, so a transfer to it updates the bus but never writes
    assign RegWrite = (state == WRITE) & |WriteReg;
`ifdef RF_WB_STATS_EN
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) conflict_cnt <= '0;
        else if (req0_valid & req1_valid & ~stall & ~&conflict_cnt) conflict_cnt <= conflict_cnt + 16'd1;
`endif
endmodule
